// File: rtl/layer_acc_sequencer.sv
// rtl/layer_acc_sequencer.sv - 3x3 conv layer sequencer: ifm stream, aligned accumulate addressing, readout sweep.
// Optional cycle counter output perf_cycles is enabled by defining LAYER_ACC_SEQ_PERF_EN.
module layer_acc_sequencer #(
    parameter int FM_LEN       = 28,
    parameter int FM_PAD       = 30,
    parameter int CONV_LATENCY = 8,
    parameter int ADDR_W       = 16,
    parameter int GROUP_W      = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [GROUP_W-1:0] num_groups,
    output logic               ifm_rd_en,
    output logic [ADDR_W-1:0]  ifm_pix_idx,
    output logic [GROUP_W-1:0] in_ch_group_count,
    output logic [ADDR_W-1:0]  acc_read_addr,
    output logic               acc_write_we_b,
    output logic [ADDR_W-1:0]  acc_write_addr,
    output logic               readout_valid,
    output logic               busy,
    output logic               done
`ifdef LAYER_ACC_SEQ_PERF_EN
    ,
    output logic [31:0]        perf_cycles
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_STREAM  = 3'd1;
    localparam logic [2:0] S_FLUSH   = 3'd2;
    localparam logic [2:0] S_READOUT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam int DLY = CONV_LATENCY + 1;
    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(FM_PAD * FM_PAD - 1);
    localparam logic [ADDR_W-1:0] C_LAST   = ADDR_W'(FM_PAD - 1);
    localparam logic [ADDR_W-1:0] RO_LAST  = ADDR_W'(FM_LEN * FM_LEN - 1);
    localparam logic [ADDR_W-1:0] FL_LAST  = ADDR_W'(CONV_LATENCY + 1);
    localparam logic [ADDR_W-1:0] WIN_MIN  = ADDR_W'(2);

    logic [2:0]         state_q, state_d;
    logic [GROUP_W-1:0] ng_q, ng_d;
    logic [GROUP_W-1:0] group_q, group_d;
    logic [ADDR_W-1:0]  pix_q, pix_d;
    logic [ADDR_W-1:0]  r_q, r_d;
    logic [ADDR_W-1:0]  c_q, c_d;
    logic [ADDR_W-1:0]  tgt_q, tgt_d;
    logic [ADDR_W-1:0]  flush_q, flush_d;
    logic [ADDR_W-1:0]  ro_addr_q, ro_addr_d;
    logic               rv_q;
    logic [DLY-1:0]     tag_v_q;
    logic [ADDR_W-1:0]  tag_a_q [DLY];
    logic               win;

    // Window pixels arrive in raster order, so their targets are simply consecutive.
    assign win = (state_q == S_STREAM) && (r_q >= WIN_MIN) && (c_q >= WIN_MIN);

    always_comb begin
        state_d   = state_q;
        ng_d      = ng_q;
        group_d   = group_q;
        pix_d     = pix_q;
        r_d       = r_q;
        c_d       = c_q;
        tgt_d     = tgt_q;
        flush_d   = flush_q;
        ro_addr_d = ro_addr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_STREAM;
                    ng_d      = (num_groups == '0) ? GROUP_W'(1) : num_groups;
                    group_d   = '0;
                    pix_d     = '0;
                    r_d       = '0;
                    c_d       = '0;
                    tgt_d     = '0;
                    ro_addr_d = '0;
                end
            end
            S_STREAM: begin
                pix_d = pix_q + 1'b1;
                if (c_q == C_LAST) begin
                    c_d = '0;
                    r_d = r_q + 1'b1;
                end else begin
                    c_d = c_q + 1'b1;
                end
                if (win) begin
                    tgt_d = tgt_q + 1'b1;
                end
                if (pix_q == PIX_LAST) begin
                    state_d = S_FLUSH;
                    flush_d = '0;
                    pix_d   = '0;
                    r_d     = '0;
                    c_d     = '0;
                    tgt_d   = '0;
                end
            end
            S_FLUSH: begin
                flush_d = flush_q + 1'b1;
                if (flush_q == FL_LAST) begin
                    if (group_q == ng_q - 1'b1) begin
                        state_d   = S_READOUT;
                        ro_addr_d = '0;
                    end else begin
                        group_d = group_q + 1'b1;
                        state_d = S_STREAM;
                    end
                end
            end
            S_READOUT: begin
                ro_addr_d = ro_addr_q + 1'b1;
                if (ro_addr_q == RO_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ng_q      <= GROUP_W'(1);
            group_q   <= '0;
            pix_q     <= '0;
            r_q       <= '0;
            c_q       <= '0;
            tgt_q     <= '0;
            flush_q   <= '0;
            ro_addr_q <= '0;
            rv_q      <= 1'b0;
            tag_v_q   <= '0;
            for (int i = 0; i < DLY; i++) begin
                tag_a_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ng_q       <= ng_d;
            group_q    <= group_d;
            pix_q      <= pix_d;
            r_q        <= r_d;
            c_q        <= c_d;
            tgt_q      <= tgt_d;
            flush_q    <= flush_d;
            ro_addr_q  <= ro_addr_d;
            rv_q       <= (state_q == S_READOUT);
            tag_v_q    <= {tag_v_q[DLY-2:0], win};
            tag_a_q[0] <= tgt_q;
            for (int i = 1; i < DLY; i++) begin
                tag_a_q[i] <= tag_a_q[i-1];
            end
        end
    end

`ifdef LAYER_ACC_SEQ_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            perf_q <= '0;
        end else if ((state_q != S_IDLE) && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 1'b1;
        end
    end

    assign perf_cycles = perf_q;
`endif

    // Read is one stage ahead of write so the 1-cycle read data meets the adder with the write.
    assign ifm_rd_en         = (state_q == S_STREAM);
    assign ifm_pix_idx       = pix_q;
    assign in_ch_group_count = group_q;
    assign acc_read_addr     = (state_q == S_READOUT) ? ro_addr_q :
                               (tag_v_q[DLY-2] ? tag_a_q[DLY-2] : '0);
    assign acc_write_we_b    = tag_v_q[DLY-1];
    assign acc_write_addr    = tag_v_q[DLY-1] ? tag_a_q[DLY-1] : '0;
    assign readout_valid     = rv_q;
    assign busy              = (state_q != S_IDLE);
    assign done              = (state_q == S_DONE);

endmodule

// File: doc/layer_acc_sequencer.md
Name: layer_acc_sequencer

Overview:
Control sequencer for one 3x3 conv layer engine.
- Drives the input-feature-map read stream, one padded FM_PAD x FM_PAD frame per input-channel group.
- Generates the accumulate-buffer read/write addresses, write enable and group count, pipeline-aligned so each conv result hits its accumulator entry exactly once per group.
- After the last group, sweeps the accumulate buffer for the quantize/relu/pool/threshold output path.

Parameters:
FM_LEN, 28, valid output feature-map width/height (output map is FM_LEN x FM_LEN)
FM_PAD, 30, padded input width/height streamed per group (FM_LEN+2)
CONV_LATENCY, 8, cycles from a pixel on the ifmstream ports to its summed result being valid at the accumulator adder
ADDR_W, 16, accumulate buffer address width
GROUP_W, 10, group counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse, begin layer; ignored unless IDLE
num_groups  in  GROUP_W  number of 8-channel input groups; sampled on accepted start
ifm_rd_en  out  1  request next input pixel; source presents pixel k on ifmstream one cycle after request k
ifm_pix_idx  out  ADDR_W  raster index (0..FM_PAD^2-1) of pixel being requested
in_ch_group_count  out  GROUP_W  current group index; 0 means overwrite, non-zero means accumulate
acc_read_addr  out  ADDR_W  accumulate buffer read address (1-cycle read latency)
acc_write_we_b  out  1  accumulate buffer write enable
acc_write_addr  out  ADDR_W  accumulate buffer write address
readout_valid  out  1  acc_read_data is a final result this cycle
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of readout

Behaviour:
Reset:
- All outputs are 0; FSM goes to IDLE.
- Reset mid-operation aborts immediately. No write enable is asserted in the cycle after rst.

FSM states: IDLE, STREAM, FLUSH, READOUT, DONE.
- IDLE -> STREAM on start. Latch ng = (num_groups==0) ? 1 : num_groups. Clear group and pixel counters.
- STREAM:
  - ifm_rd_en=1 every cycle; ifm_pix_idx increments 0..FM_PAD^2-1.
  - After index FM_PAD^2-1 -> FLUSH.
- FLUSH:
  - ifm_rd_en=0 for CONV_LATENCY+2 cycles.
  - Then, if group==ng-1 -> READOUT; else group+1 -> STREAM.
  - in_ch_group_count changes only on the FLUSH exit edge.
- READOUT:
  - acc_read_addr sweeps 0..FM_LEN^2-1, one per cycle; acc_write_we_b=0.
  - readout_valid is asserted one cycle after each address.
  - After the last address -> DONE.
- DONE: done=1 for one cycle; the last readout_valid is in this cycle -> IDLE.
- busy = (state != IDLE).

Address alignment:
- Requested pixel k has r=k/FM_PAD, c=k%FM_PAD.
- It is a window bottom-right if r>=2 and c>=2; its target address is (r-2)*FM_LEN+(c-2).
- Tag (valid, target address) enters a delay line when requested.
- Read: acc_read_addr=target at cycle k+CONV_LATENCY.
- Write: acc_write_we_b=1, acc_write_addr=target at cycle k+1+CONV_LATENCY, so read data meets the adder combinationally.
- Non-window pixels never write. This masks row-wrap and cross-group line-buffer garbage.
- Exactly FM_LEN^2 writes per group, each address once.

Counters:
- Use r/c counters, not division.
- Address arithmetic is unsigned ADDR_W and must not wrap for FM_LEN^2 < 2^ADDR_W.

Start while busy is ignored.

Optional Feature:
Macro: LAYER_ACC_SEQ_PERF_EN
- Defined: adds output perf_cycles (32-bit).
  - Cleared on accepted start.
  - Increments every busy cycle; saturates at 0xFFFFFFFF.
  - Holds after done until next start; 0 on reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-STREAM at pixel 100 -> next cycle all outputs 0, state IDLE; a new start restarts at ifm_pix_idx 0, group 0.
- Single group, num_groups=1, start at T=0 (first rd_en at T=1):
  - ifm_rd_en high 900 cycles.
  - First write at T=1+62+9 with addr 0; read addr 0 one cycle earlier.
  - Last write addr 783; exactly 784 writes; no write for pixel c<2 or r<2.
- Two groups, num_groups=2: all 784 group-0 writes occur with in_ch_group_count=0 and all group-1 writes with 1; no write overlaps the FLUSH gap boundary.
- Readout: after last group, acc_read_addr 0..783 consecutive; readout_valid high 784 cycles lagging by 1; done single pulse; busy falls the cycle after done.
- num_groups=0 behaves as 1; start pulse during STREAM ignored (counters unaffected).
- With LAYER_ACC_SEQ_PERF_EN and num_groups=1: perf_cycles equals the total busy-cycle count (900 + 10 + 784 + 1 = 1695) after done.
